// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, width, corner operand table and selftest LFSR step.
// No ports; imported by the ALU, alu_golden and alu_selftest.
package alu_pkg;

    localparam int N = 32;

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUBU = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [2:0] OP_SEQ [7] = '{OP_ADDU, OP_ADD, OP_OR, OP_SUBU, OP_SUB, OP_SLTU, OP_SLT};

    localparam logic [N-1:0] CORNER_A [8] = '{
        32'h7FFF_FFF1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0010,
        32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0010, 32'h0000_0000
    };
    localparam logic [N-1:0] CORNER_B [8] = '{
        32'h0000_000F, 32'h8000_0001, 32'h0000_0001, 32'h0000_0010,
        32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000
    };

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [N-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return {1'b0, s[N-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/alu_golden.sv
// alu_golden: combinational expected-value model of the ALU.
// Ports: a, b (W) operands; ctr (3) opcode; result (W); zero; overflow (signed add/sub only).
module alu_golden
    import alu_pkg::*;
#(
    parameter int W = N
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   ctr,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         overflow
);
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    assign sum  = a + b;
    assign diff = a - b;
    // sltu/slt and or are picked off first, so ctr[2] alone separates subtract from add
    assign result = ctr == OP_OR   ? a | b :
                    ctr == OP_SLTU ? W'(a < b) :
                    ctr == OP_SLT  ? W'($signed(a) < $signed(b)) :
                    ctr[2]         ? diff : sum;
    assign overflow = ctr == OP_ADD ? (a[W-1] == b[W-1] && sum[W-1] != a[W-1]) :
                      ctr == OP_SUB ? (a[W-1] != b[W-1] && diff[W-1] != a[W-1]) : 1'b0;
    assign zero = result == '0;
endmodule

// File: rtl/alu_selftest.sv
// alu_selftest: drives directed + LFSR vectors into an ALU and checks its outputs.
// Ports: clk, rst (async, active-high), start; alu_a/alu_b/alu_ctr to the ALU;
// alu_result/alu_zero/alu_overflow from the ALU; busy, done, pass, err_count, vec_count.
// Define ALU_SELFTEST_FAILCAP_EN to add fail_valid/fail_idx/fail_a/fail_b/fail_ctr/
// fail_result/fail_flags capturing the first mismatching vector of a run.
module alu_selftest
    import alu_pkg::*;
#(
    parameter int           NUM_VEC = 64,
    parameter int           SETTLE  = 2,
    parameter logic [N-1:0] SEED    = 32'hACE1_2025
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_ctr,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_overflow,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [15:0]  vec_count
`ifdef ALU_SELFTEST_FAILCAP_EN
    ,
    output logic         fail_valid,
    output logic [15:0]  fail_idx,
    output logic [N-1:0] fail_a,
    output logic [N-1:0] fail_b,
    output logic [2:0]   fail_ctr,
    output logic [N-1:0] fail_result,
    output logic [1:0]   fail_flags
`endif
);
    state_t       state;
    logic [N-1:0] lfsr;
    logic [2:0]   op_i;
    logic [15:0]  wait_cnt;
    logic [N-1:0] exp_result;
    logic         exp_zero;
    logic         exp_ovf;
    logic         corner;
    logic [N-1:0] step1;
    logic [N-1:0] step2;
    logic [N-1:0] nxt_a;
    logic [N-1:0] nxt_b;
    logic [N-1:0] g_result;
    logic         g_zero;
    logic         g_ovf;
    logic         mismatch;

    // vec_count doubles as the index of the vector about to be driven
    assign corner = vec_count < 16'd8;
    assign step1  = lfsr_step(lfsr);
    assign step2  = lfsr_step(step1);
    assign nxt_a  = corner ? CORNER_A[vec_count[2:0]] : step1;
    assign nxt_b  = corner ? CORNER_B[vec_count[2:0]] : step2;
    assign mismatch = {alu_result, alu_zero, alu_overflow} != {exp_result, exp_zero, exp_ovf};

    alu_golden #(.W(N)) u_golden (
        .a        (nxt_a),
        .b        (nxt_b),
        .ctr      (OP_SEQ[op_i]),
        .result   (g_result),
        .zero     (g_zero),
        .overflow (g_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr       <= SEED;
            op_i       <= '0;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctr    <= OP_ADDU;
            exp_result <= '0;
            exp_zero   <= 1'b0;
            exp_ovf    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
`ifdef ALU_SELFTEST_FAILCAP_EN
            fail_valid  <= 1'b0;
            fail_idx    <= '0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_ctr    <= '0;
            fail_result <= '0;
            fail_flags  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // In DONE, start counts only once done is visible; until then the run is still busy
                    if (start && (state == ST_IDLE || done)) begin
                        state     <= ST_DRIVE;
                        lfsr      <= SEED;
                        op_i      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_count <= '0;
`ifdef ALU_SELFTEST_FAILCAP_EN
                        fail_valid  <= 1'b0;
                        fail_idx    <= '0;
                        fail_a      <= '0;
                        fail_b      <= '0;
                        fail_ctr    <= '0;
                        fail_result <= '0;
                        fail_flags  <= '0;
`endif
                    end else if (state == ST_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= err_count == '0;
                    end
                end
                ST_DRIVE: begin
                    alu_a      <= nxt_a;
                    alu_b      <= nxt_b;
                    alu_ctr    <= OP_SEQ[op_i];
                    exp_result <= g_result;
                    exp_zero   <= g_zero;
                    exp_ovf    <= g_ovf;
                    lfsr       <= corner ? lfsr : step2;
                    op_i       <= op_i == 3'd6 ? 3'd0 : op_i + 3'd1;
                    wait_cnt   <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    state    <= wait_cnt == 16'(SETTLE - 1) ? ST_CHECK : ST_WAIT;
                end
                ST_CHECK: begin
                    if (mismatch && err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
`ifdef ALU_SELFTEST_FAILCAP_EN
                    if (mismatch && !fail_valid) begin
                        fail_valid  <= 1'b1;
                        fail_idx    <= vec_count;
                        fail_a      <= alu_a;
                        fail_b      <= alu_b;
                        fail_ctr    <= alu_ctr;
                        fail_result <= alu_result;
                        fail_flags  <= {alu_zero, alu_overflow};
                    end
`endif
                    vec_count <= vec_count + 16'd1;
                    state     <= vec_count + 16'd1 == 16'(NUM_VEC) ? ST_DONE : ST_DRIVE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_selftest.md
Name: alu_selftest

Overview:
- Sequential stimulus and checker engine for the 32-bit combinational ALU: it sits on the initiator side of the ALU's A/B/ALUctr → Result/Zero/Overflow interface.
- On a start pulse it drives a directed-plus-pseudo-random operand/opcode sequence into the ALU and waits a fixed settle time.
- It then compares Result, Zero and Overflow against an internal golden model and reports a pass/fail verdict and an error count.
- Used for on-board self-test and as a reusable bench driver for the ALU lab.

Parameters:
- N, 32, operand/result width.
- NUM_VEC, 64, vectors per run (min 8, max 65535).
- SETTLE, 2, cycles to wait after driving before sampling ALU outputs (min 1).
- SEED, 32'hACE1_2025, LFSR seed loaded at each start (non-zero).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle run request.
- alu_a  output  N  ALU operand A.
- alu_b  output  N  ALU operand B.
- alu_ctr  output  3  ALU opcode.
- alu_result  input  N  ALU Result.
- alu_zero  input  1  ALU Zero.
- alu_overflow  input  1  ALU Overflow.
- busy  output  1  run in progress.
- done  output  1  run finished; held until next start.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  16  mismatching vectors, saturates at 16'hFFFF.
- vec_count  output  16  vectors checked so far in this run.

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset: all outputs 0, alu_ctr=3'b000, FSM=IDLE, LFSR=SEED. Asserting rst mid-run aborts immediately; no partial verdict.
- Opcodes:
  - 000 addu, Overflow=0.
  - 001 add, signed overflow.
  - 010 or.
  - 100 subu, Overflow=0.
  - 101 sub, signed overflow.
  - 110 sltu, Result=32'd1/0.
  - 111 slt, signed.
  - Zero = (Result==0) for every opcode.
  - 011 is never issued.
- Op sequence: vector i uses op_seq[i mod 7] = 000,001,010,100,101,110,111.
- Operands:
  - Vectors 0-7 come from a fixed corner table, in order: (7FFFFFF1,0000000F), (80000001,80000001), (FFFFFFFF,00000001), (00000010,00000010), (7FFFFFFF,FFFFFFFF), (80000001,00000002), (00000010,FFFFFFFF), (00000000,00000000).
  - Vectors ≥8 take A and B from two consecutive steps of a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
- Add/sub arithmetic is modulo 2^N.
- Signed overflow:
  - add: sign(A)==sign(B) and sign(R)!=sign(A).
  - sub: sign(A)!=sign(B) and sign(R)!=sign(A).
- FSM IDLE:
  - start → DRIVE; clears err_count and vec_count, reloads LFSR, sets busy=1 and done=0.
- FSM DRIVE (1 cycle):
  - Registers alu_a, alu_b, alu_ctr and the expected triple.
  - → WAIT.
- FSM WAIT:
  - Counts SETTLE cycles.
  - → CHECK.
- FSM CHECK (1 cycle):
  - Compares all three ALU outputs with expected; any mismatch increments err_count (saturating).
  - Increments vec_count.
  - If vec_count reaches NUM_VEC → DONE, else → DRIVE.
- FSM DONE:
  - busy=0, done=1, pass valid; alu_* hold the last values.
  - start → DRIVE as from IDLE.
- Latency: done rises exactly NUM_VEC*(SETTLE+2)+1 cycles after the cycle start is sampled high.
- start while busy is ignored.
- start and rst together: rst wins.

Optional Feature:
- ALU_SELFTEST_FAILCAP_EN defined:
  - Adds outputs fail_valid (1), fail_idx (16), fail_a (N), fail_b (N), fail_ctr (3), fail_result (N), fail_flags (2: {zero, overflow}).
  - These capture the first mismatching vector of a run, clear on start and reset to 0.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADDU, OP_ADD, OP_OR, OP_SUBU, OP_SUB, OP_SLTU, OP_SLT;
  - width constant N=32;
  - the 8-entry corner operand table.
- The ALU itself should import the same opcode constants.
- One natural sub-module: alu_golden, a combinational expected-value model (a, b, ctr → result, zero, overflow) instantiated inside alu_selftest and reusable by benches.

Test Plan:
- Reset then start, with a correct ALU, NUM_VEC=8, SETTLE=2 → done exactly 33 cycles after start; pass=1, err_count=0, vec_count=8.
- Vector 1 (add, 80000001+80000001) → alu_ctr=001 driven, expected result 00000002, overflow=1; vector 0 (addu, 7FFFFFF1+F) → expected 80000000, overflow=0.
- Faulty ALU with Result bit 0 forced to 1, NUM_VEC=8 → err_count=8 minus the vectors whose correct bit 0 is already 1, pass=0; with the macro, fail_idx equals the first such vector.
- ALU that ignores Overflow (tied 0), NUM_VEC=64 → err_count equals the count of overflowing 001/101 vectors, at least 2 (corner vectors 1 and 4).
- Assert rst during WAIT of vector 3 → outputs return to 0 asynchronously and busy=0; a new start reruns from vector 0, with identical alu_a/alu_b sequence after the same SEED.
- start pulsed while busy, then again in DONE → first pulse ignored, second begins a fresh run with counts cleared.
